// File: rtl/soc_host_wb_32_pkg.sv
// Shared types and protocol constants for the host-side Wishbone-to-byte-stream bridge.
package soc_host_wb_32_pkg;

  // Frame constants; the device-side block uses the same values
  localparam logic [3:0] CMD_READ   = 4'hA;
  localparam logic [3:0] CMD_WRITE  = 4'hB;
  localparam logic [7:0] START_FLAG = 8'h01;
  localparam logic [7:0] TERM_BYTE  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_RWAIT_START,
    ST_RDATA,
    ST_TERM,
    ST_DRAIN,
    ST_RESP
  } state_t;

  // Result of decoding a Wishbone byte-select for a write
  typedef struct packed {
    logic       ok;    // non-zero and contiguous
    logic       zero;  // no lanes selected
    logic [1:0] off;   // lowest selected lane
    logic [2:0] n;     // number of selected lanes
  } sel_dec_t;

endpackage

// File: rtl/soc_host_wb_32.sv
// Wishbone slave that serialises each 32-bit access into a command frame on an
// 8-bit output stream and parses the device's read-response frame.
module soc_host_wb_32
  import soc_host_wb_32_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic        wb_cyc_i,
  output logic [7:0]  output_axis_tdata,
  output logic        output_axis_tvalid,
  input  logic        output_axis_tready,
  output logic        output_axis_tlast,
  input  logic [7:0]  input_axis_tdata,
  input  logic        input_axis_tvalid,
  output logic        input_axis_tready,
  input  logic        input_axis_tlast,
  output logic        busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [35:2]       r_adr;
  logic [31:0]       r_dat;
  logic              r_we;
  logic [1:0]        r_off;
  logic [2:0]        r_n;
  logic              r_abort, w_abort_nxt;
  logic              r_tmo_err, w_tmo_err_nxt;
  logic [TW-1:0]     r_tmo, w_tmo_nxt;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic [7:0]        r_tdata, w_tdata_nxt;
  logic              r_tvalid, w_tvalid_nxt;
  logic              r_tlast, w_tlast_nxt;
  logic              r_ack, w_ack_nxt;
  logic              r_err, w_err_nxt;
  logic [31:0]       r_dat_o, w_dat_o_nxt;
  logic              r_in_ready, w_in_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_accept, w_hs_out, w_hs_in, w_tmo_hit;
  sel_dec_t          w_dec;
  logic              w_unused;

  // Lowest lane, lane count and contiguity of a write byte-select
  function automatic sel_dec_t decode_sel(input logic [3:0] sel);
    sel_dec_t   d;
    logic [3:0] mask;
    d = '0;
    for (int i = 3; i >= 0; i--) begin
      if (sel[i]) begin
        d.off = 2'(i);
        d.n   = d.n + 3'd1;
      end
    end
    case (d.n)
      3'd1:    mask = 4'h1;
      3'd2:    mask = 4'h3;
      3'd3:    mask = 4'h7;
      3'd4:    mask = 4'hF;
      default: mask = 4'h0;
    endcase
    d.zero = (sel == 4'h0);
    d.ok   = !d.zero && ((sel >> d.off) == mask);
    return d;
  endfunction

  // Header byte idx (0..4) of a command frame, MSB first
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [35:2] adr,
                                          input logic we, input logic [1:0] off);
    case (idx)
      3'd0:    hdr_byte = {(we ? CMD_WRITE : CMD_READ), adr[35:32]};
      3'd1:    hdr_byte = adr[31:24];
      3'd2:    hdr_byte = adr[23:16];
      3'd3:    hdr_byte = adr[15:8];
      default: hdr_byte = {adr[7:2], (we ? off : 2'b00)};
    endcase
  endfunction

  // Write payload byte idx counted upward from the lowest selected lane
  function automatic logic [7:0] data_byte(input logic [31:0] dat, input logic [1:0] off,
                                           input logic [1:0] idx);
    logic [1:0] pos;
    pos = off + idx;
    return dat[{pos, 3'b000} +: 8];
  endfunction

  assign w_dec     = decode_sel(wb_sel_i);
  assign w_accept  = (r_state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_hs_out  = r_tvalid && output_axis_tready;
  assign w_hs_in   = input_axis_tvalid && r_in_ready;
  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo == TMO_LAST);
  assign w_unused  = &{1'b0, wb_adr_i[1:0]};

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_abort_nxt   = r_abort | ((r_state != ST_IDLE) && !wb_cyc_i);
    w_tmo_err_nxt = r_tmo_err;
    w_tmo_nxt     = r_tmo;
    w_rdata_nxt   = r_rdata;
    w_tdata_nxt   = r_tdata;
    w_tvalid_nxt  = r_tvalid;
    w_tlast_nxt   = r_tlast;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_dat_o_nxt   = r_dat_o;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_abort_nxt   = 1'b0;
          w_tmo_err_nxt = 1'b0;
          if (wb_we_i && w_dec.zero) begin
            w_state_nxt = ST_RESP;
            w_ack_nxt   = 1'b1;
          end else if (wb_we_i && !w_dec.ok) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt  = ST_HDR;
            w_cnt_nxt    = 3'd0;
            w_tvalid_nxt = 1'b1;
            w_tlast_nxt  = 1'b0;
            w_tdata_nxt  = hdr_byte(3'd0, wb_adr_i[35:2], wb_we_i, w_dec.off);
          end
        end
      end

      ST_HDR: begin
        if (w_hs_out) begin
          if (r_cnt == 3'd4) begin
            w_cnt_nxt = 3'd0;
            if (r_we) begin
              w_state_nxt = ST_WDATA;
              w_tdata_nxt = data_byte(r_dat, r_off, 2'd0);
              w_tlast_nxt = (r_n == 3'd1);
            end else begin
              w_state_nxt  = ST_RWAIT_START;
              w_tvalid_nxt = 1'b0;
              w_tmo_nxt    = '0;
            end
          end else begin
            w_cnt_nxt   = r_cnt + 3'd1;
            w_tdata_nxt = hdr_byte(r_cnt + 3'd1, r_adr, r_we, r_off);
          end
        end
      end

      ST_WDATA: begin
        if (w_hs_out) begin
          if (r_cnt == r_n - 3'd1) begin
            w_state_nxt  = ST_RESP;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_ack_nxt    = !w_abort_nxt;
          end else begin
            w_cnt_nxt   = r_cnt + 3'd1;
            w_tdata_nxt = data_byte(r_dat, r_off, r_cnt[1:0] + 2'd1);
            w_tlast_nxt = ((r_cnt + 3'd2) == r_n);
          end
        end
      end

      ST_RWAIT_START: begin
        if (w_hs_in) begin
          w_tmo_nxt = '0;
          if (input_axis_tlast) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = !w_abort_nxt;
          end else if (input_axis_tdata == START_FLAG) begin
            w_state_nxt = ST_RDATA;
            w_cnt_nxt   = 3'd0;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt   = ST_TERM;
          w_tmo_err_nxt = 1'b1;
          w_tvalid_nxt  = 1'b1;
          w_tdata_nxt   = TERM_BYTE;
          w_tlast_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      ST_RDATA: begin
        if (w_hs_in) begin
          w_tmo_nxt = '0;
          w_rdata_nxt[{r_cnt[1:0], 3'b000} +: 8] = input_axis_tdata;
          if (input_axis_tlast) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = !w_abort_nxt;
          end else if (r_cnt == 3'd3) begin
            w_state_nxt  = ST_TERM;
            w_tvalid_nxt = 1'b1;
            w_tdata_nxt  = TERM_BYTE;
            w_tlast_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt   = ST_TERM;
          w_tmo_err_nxt = 1'b1;
          w_tvalid_nxt  = 1'b1;
          w_tdata_nxt   = TERM_BYTE;
          w_tlast_nxt   = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      ST_TERM: begin
        if (w_hs_out) begin
          w_tvalid_nxt = 1'b0;
          w_tlast_nxt  = 1'b0;
          if (r_tmo_err) begin
            w_state_nxt = ST_RESP;
            w_err_nxt   = !w_abort_nxt;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_tmo_nxt   = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (w_hs_in) begin
          w_tmo_nxt = '0;
          if (input_axis_tlast) begin
            w_state_nxt = ST_RESP;
            w_ack_nxt   = !w_abort_nxt;
            w_dat_o_nxt = r_rdata;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = !w_abort_nxt;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RWAIT_START) ||
                     (w_state_nxt == ST_RDATA) || (w_state_nxt == ST_DRAIN);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  // Control state and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_abort    <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_tmo      <= '0;
      r_tdata    <= 8'h00;
      r_tvalid   <= 1'b0;
      r_tlast    <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat_o    <= 32'h0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_abort    <= w_abort_nxt;
      r_tmo_err  <= w_tmo_err_nxt;
      r_tmo      <= w_tmo_nxt;
      r_tdata    <= w_tdata_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tlast    <= w_tlast_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_dat_o    <= w_dat_o_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Access latch and read-data assembly; pure datapath, no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_adr <= wb_adr_i[35:2];
      r_dat <= wb_dat_i;
      r_we  <= wb_we_i;
      r_off <= w_dec.off;
      r_n   <= w_dec.n;
    end
    r_rdata <= w_rdata_nxt;
  end

  assign wb_dat_o           = r_dat_o;
  assign wb_ack_o           = r_ack;
  assign wb_err_o           = r_err;
  assign output_axis_tdata  = r_tdata;
  assign output_axis_tvalid = r_tvalid;
  assign output_axis_tlast  = r_tlast;
  assign input_axis_tready  = r_in_ready;
  assign busy               = r_busy;

endmodule

// File: tb/tb_soc_host_wb_32.sv
// Scoreboard bench for soc_host_wb_32: expected frame bytes are queued when an
// access is issued and popped as the DUT hands bytes over the output stream.
module tb_soc_host_wb_32;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_cyc_i;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic        output_axis_tlast;
  logic [7:0]  input_axis_tdata;
  logic        input_axis_tvalid;
  logic        input_axis_tready;
  logic        input_axis_tlast;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  exp_q[$];   // {tlast, tdata} expected on the output stream
  logic [8:0]  in_q[$];    // {tlast, tdata} the device stub will send
  int          out_cyc[$];
  int          cyc_cnt = 0;
  int          n_out = 0;
  int          ack_seen = 0;
  int          err_seen = 0;
  int          resp_tick = 0;
  int          tick_in_txn = 0;
  logic [31:0] dat_at_ack = 32'h0;
  bit          rnd_ready = 1'b0;

  soc_host_wb_32 #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_cyc_i(wb_cyc_i),
    .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tready(output_axis_tready), .output_axis_tlast(output_axis_tlast),
    .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tready(input_axis_tready), .input_axis_tlast(input_axis_tlast),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_in();
    if (in_q.size() != 0) begin
      input_axis_tvalid = 1'b1;
      {input_axis_tlast, input_axis_tdata} = in_q[0];
    end else begin
      input_axis_tvalid = 1'b0;
      input_axis_tlast  = 1'b0;
      input_axis_tdata  = 8'h00;
    end
  endtask

  // One clock: observe at negedge, then update stimulus just after posedge
  task automatic tick();
    logic [8:0] exp_b;
    bit         resp;
    resp = 1'b0;
    @(negedge clk);
    cyc_cnt++;
    tick_in_txn++;
    if (output_axis_tvalid && output_axis_tready) begin
      n_out++;
      out_cyc.push_back(cyc_cnt);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_byte: got %h tlast=%b, expected no byte", output_axis_tdata, output_axis_tlast);
      end else begin
        exp_b = exp_q.pop_front();
        if ({output_axis_tlast, output_axis_tdata} !== exp_b) begin
          n_fail++;
          $display("FAIL out_byte #%0d: got tlast=%b data=%h, expected tlast=%b data=%h",
                   n_out, output_axis_tlast, output_axis_tdata, exp_b[8], exp_b[7:0]);
        end
      end
    end
    if (input_axis_tvalid && input_axis_tready && in_q.size() != 0) void'(in_q.pop_front());
    if (wb_ack_o) begin ack_seen++; dat_at_ack = wb_dat_o; resp = 1'b1; resp_tick = tick_in_txn; end
    if (wb_err_o) begin err_seen++; resp = 1'b1; resp_tick = tick_in_txn; end
    @(posedge clk);
    #1;
    if (resp) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
    output_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_in();
  endtask

  task automatic wb_issue(input logic [35:0] adr, input logic [31:0] dat,
                          input logic we, input logic [3:0] sel);
    wb_adr_i = adr; wb_dat_i = dat; wb_we_i = we; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n_out = 0; ack_seen = 0; err_seen = 0; tick_in_txn = 0; resp_tick = 0;
    out_cyc.delete();
  endtask

  task automatic wait_out(input int n, input int budget);
    int k;
    k = 0;
    while (n_out < n && k < budget) begin tick(); k++; end
    n_tests++;
    if (n_out < n) begin
      n_fail++;
      $display("FAIL wait_out: saw %0d bytes, required %0d within %0d cycles", n_out, n, budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((wb_stb_i || busy) && k < budget) begin tick(); k++; end
    n_tests++;
    if (busy !== 1'b0 || wb_stb_i) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b stb=%b after %0d cycles, required idle", busy, wb_stb_i, budget);
    end
  endtask

  task automatic push_hdr(input logic [3:0] cmd, input logic [35:0] adr, input logic [1:0] low);
    exp_q.push_back({1'b0, cmd, adr[35:32]});
    exp_q.push_back({1'b0, adr[31:24]});
    exp_q.push_back({1'b0, adr[23:16]});
    exp_q.push_back({1'b0, adr[15:8]});
    exp_q.push_back({1'b0, adr[7:2], low});
  endtask

  task automatic do_full_write(input string tag);
    push_hdr(4'hB, 36'h1_2345_6788, 2'b00);
    exp_q.push_back(9'h0EF); exp_q.push_back(9'h0BE);
    exp_q.push_back(9'h0AD); exp_q.push_back(9'h1DE);
    wb_issue(36'h1_2345_6788, 32'hDEADBEEF, 1'b1, 4'b1111);
    wait_idle(100);
    n_tests++;
    if (ack_seen !== 1 || err_seen !== 0) begin
      n_fail++;
      $display("FAIL %s resp: ack=%0d err=%0d, required ack=1 err=0", tag, ack_seen, err_seen);
    end
    n_tests++;
    if (n_out !== 9 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s bytes: sent %0d, %0d left, required 9 and 0", tag, n_out, exp_q.size());
    end
    n_tests++;
    if (!rnd_ready && resp_tick !== 11) begin
      n_fail++;
      $display("FAIL %s latency: ack on cycle %0d, required 11", tag, resp_tick);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_tests++;
    if ({output_axis_tvalid, output_axis_tlast, output_axis_tdata, wb_ack_o, wb_err_o,
         wb_dat_o, input_axis_tready, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h ack=%b err=%b dat=%h tready=%b busy=%b, required all 0",
               output_axis_tvalid, output_axis_tdata, wb_ack_o, wb_err_o, wb_dat_o, input_axis_tready, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();
    n_tests++;
    if (input_axis_tready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: tready=%b busy=%b, required 1 and 0", input_axis_tready, busy);
    end
  endtask

  task automatic test_write_partial();
    // sel=0110: off=1, two bytes, last header byte carries the offset
    push_hdr(4'hB, 36'h1_2345_6788, 2'b01);
    exp_q.push_back(9'h0BE); exp_q.push_back(9'h1AD);
    wb_issue(36'h1_2345_6788, 32'hDEADBEEF, 1'b1, 4'b0110);
    wait_idle(100);
    n_tests++;
    if (ack_seen !== 1 || err_seen !== 0 || n_out !== 7) begin
      n_fail++;
      $display("FAIL partial_0110: ack=%0d err=%0d bytes=%0d, required 1 0 7", ack_seen, err_seen, n_out);
    end
    // sel=1000: single top byte
    push_hdr(4'hB, 36'h1_2345_6788, 2'b11);
    exp_q.push_back(9'h1DE);
    wb_issue(36'h1_2345_6788, 32'hDEADBEEF, 1'b1, 4'b1000);
    wait_idle(100);
    n_tests++;
    if (ack_seen !== 1 || n_out !== 6) begin
      n_fail++;
      $display("FAIL partial_1000: ack=%0d bytes=%0d, required 1 6", ack_seen, n_out);
    end
  endtask

  task automatic test_sel_corner();
    wb_issue(36'h1_2345_6788, 32'hDEADBEEF, 1'b1, 4'b0101);
    wait_idle(20);
    n_tests++;
    if (err_seen !== 1 || ack_seen !== 0 || n_out !== 0 || resp_tick !== 2) begin
      n_fail++;
      $display("FAIL sel_noncontig: err=%0d ack=%0d bytes=%0d cycle=%0d, required 1 0 0 2",
               err_seen, ack_seen, n_out, resp_tick);
    end
    wb_issue(36'h1_2345_6788, 32'hDEADBEEF, 1'b1, 4'b0000);
    wait_idle(20);
    n_tests++;
    if (ack_seen !== 1 || err_seen !== 0 || n_out !== 0 || resp_tick !== 2) begin
      n_fail++;
      $display("FAIL sel_zero: ack=%0d err=%0d bytes=%0d cycle=%0d, required 1 0 0 2",
               ack_seen, err_seen, n_out, resp_tick);
    end
  endtask

  task automatic test_read();
    // read ignores sel, so a non-contiguous select must still produce a frame
    push_hdr(4'hA, 36'h0_0000_1004, 2'b00);
    exp_q.push_back(9'h100);
    wb_issue(36'h0_0000_1004, 32'h0, 1'b0, 4'b0101);
    wait_out(5, 50);
    in_q.push_back(9'h055); in_q.push_back(9'h001);
    in_q.push_back(9'h078); in_q.push_back(9'h056);
    in_q.push_back(9'h034); in_q.push_back(9'h012);
    in_q.push_back(9'h09A); in_q.push_back(9'h100);
    wait_idle(200);
    n_tests++;
    if (ack_seen !== 1 || err_seen !== 0) begin
      n_fail++;
      $display("FAIL read_resp: ack=%0d err=%0d, required 1 0", ack_seen, err_seen);
    end
    n_tests++;
    if (dat_at_ack !== 32'h12345678) begin
      n_fail++;
      $display("FAIL read_data: got %h, required 12345678", dat_at_ack);
    end
    n_tests++;
    if (n_out !== 6 || in_q.size() !== 0) begin
      n_fail++;
      $display("FAIL read_frames: sent %0d, stub left %0d, required 6 and 0", n_out, in_q.size());
    end
  endtask

  task automatic test_read_tlast_err();
    push_hdr(4'hA, 36'hF_0000_0010, 2'b00);
    wb_issue(36'hF_0000_0010, 32'h0, 1'b0, 4'b1111);
    wait_out(5, 50);
    in_q.push_back(9'h001); in_q.push_back(9'h078); in_q.push_back(9'h156);
    wait_idle(100);
    n_tests++;
    if (err_seen !== 1 || ack_seen !== 0 || n_out !== 5 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL read_early_tlast: err=%0d ack=%0d bytes=%0d, required 1 0 5", err_seen, ack_seen, n_out);
    end
  endtask

  task automatic test_timeout();
    push_hdr(4'hA, 36'h0_0000_1004, 2'b00);
    exp_q.push_back(9'h100);
    wb_issue(36'h0_0000_1004, 32'h0, 1'b0, 4'b1111);
    wait_idle(200);
    n_tests++;
    if (err_seen !== 1 || ack_seen !== 0 || n_out !== 6) begin
      n_fail++;
      $display("FAIL timeout_resp: err=%0d ack=%0d bytes=%0d, required 1 0 6", err_seen, ack_seen, n_out);
    end
    // terminator transfers TMO+1 cycles after the last header byte transfers
    n_tests++;
    if (out_cyc.size() < 6) begin
      n_fail++;
      $display("FAIL timeout_gap: only %0d bytes seen, required 6", out_cyc.size());
    end else if (out_cyc[5] - out_cyc[4] !== TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_gap: got %0d cycles, required %0d", out_cyc[5] - out_cyc[4], TMO + 1);
    end
  endtask

  task automatic test_backpressure();
    rnd_ready = 1'b1;
    do_full_write("backpressure");
    rnd_ready = 1'b0;
  endtask

  task automatic test_abort();
    push_hdr(4'hB, 36'h1_2345_6788, 2'b00);
    exp_q.push_back(9'h0EF); exp_q.push_back(9'h0BE);
    exp_q.push_back(9'h0AD); exp_q.push_back(9'h1DE);
    wb_issue(36'h1_2345_6788, 32'hDEADBEEF, 1'b1, 4'b1111);
    wait_out(2, 20);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wait_idle(100);
    n_tests++;
    if (ack_seen !== 0 || err_seen !== 0 || n_out !== 9 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL abort: ack=%0d err=%0d bytes=%0d, required 0 0 9", ack_seen, err_seen, n_out);
    end
  endtask

  task automatic test_reset_midread();
    push_hdr(4'hA, 36'h0_0000_1004, 2'b00);
    wb_issue(36'h0_0000_1004, 32'h0, 1'b0, 4'b1111);
    wait_out(3, 20);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({output_axis_tvalid, output_axis_tlast, output_axis_tdata, wb_ack_o, wb_err_o,
         wb_dat_o, input_axis_tready, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_midread: tvalid=%b tdata=%h dat=%h tready=%b busy=%b, required all 0",
               output_axis_tvalid, output_axis_tdata, wb_dat_o, input_axis_tready, busy);
    end
    exp_q.delete();
    in_q.delete();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    drive_in();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(); tick();
    do_full_write("after_reset");
  endtask

  initial begin
    wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_sel_i = '0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    output_axis_tready = 1'b1;
    input_axis_tvalid = 1'b0; input_axis_tdata = '0; input_axis_tlast = 1'b0;
    test_reset();
    do_full_write("write_full");
    test_write_partial();
    test_sel_corner();
    test_read();
    test_read_tlast_err();
    test_timeout();
    test_backpressure();
    test_abort();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
